// File: rtl/sign_extrinsic_dist.sv
// sign_extrinsic_dist: serial sign back-end of the shuffled variable-node unit.
// Collects DEG edge signs plus the channel sign, issues the majority hard
// decision, then streams one leave-one-out extrinsic sign per edge.
// Optional build macro: SIGN_FLIP_STAT_EN adds o_flip_cnt, a saturating count
// of frames whose hard decision disagrees with the channel sign.
module sign_extrinsic_dist #(
  parameter int unsigned DEG   = 4,
  parameter int unsigned CNT_W = $clog2(DEG + 2),
  parameter int unsigned IDX_W = $clog2(DEG)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sign,
  input  logic             i_chan_sign,
  output logic             o_hard_valid,
  output logic             o_hard,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
`ifdef SIGN_FLIP_STAT_EN
  ,
  output logic [15:0]      o_flip_cnt
`endif
);

  localparam int unsigned      W2       = CNT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG - 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_DECIDE,
    S_EMIT
  } state_t;

  state_t           r_state;
  logic [DEG-1:0]   r_buf;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] r_total;
  logic             r_chan;
  logic [IDX_W-1:0] r_in_idx;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_ready;
  logic             r_hard_valid;
  logic             r_hard;
  logic             r_valid;
  logic             r_sign;
  logic             r_last;
`ifdef SIGN_FLIP_STAT_EN
  logic [15:0]      r_flip_cnt;
`endif

  logic             w_accept_in;
  logic             w_accept_out;
  logic [CNT_W-1:0] w_total;
  logic             w_hard;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_sign0;
  logic             w_sign_nx;

  // Majority with tie-break: compares twice the vote count against the voter count.
  function automatic logic f_vote(input logic [W2-1:0] twice_yes,
                                  input logic [W2-1:0] voters,
                                  input logic          tie);
    if (twice_yes > voters)      return 1'b1;
    else if (twice_yes < voters) return 1'b0;
    else                         return tie;
  endfunction

  // Handshakes, frame total and the vote results feeding the registers.
  always_comb begin
    w_accept_in  = i_valid && r_ready && (r_state == S_COLLECT);
    w_accept_out = r_valid && i_ready;
    w_total      = r_ones + CNT_W'(r_chan);
    w_hard       = f_vote({w_total, 1'b0}, W2'(DEG + 1), r_chan);
    w_next_idx   = r_out_idx + IDX_W'(1);
    w_sign0      = f_vote({w_total - CNT_W'(r_buf[0]), 1'b0}, W2'(DEG), r_chan);
    w_sign_nx    = f_vote({r_total - CNT_W'(r_buf[w_next_idx]), 1'b0}, W2'(DEG), r_chan);
  end

  // Frame FSM: collect signs, decide for one cycle, emit extrinsic signs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_COLLECT;
      r_buf        <= '0;
      r_ones       <= '0;
      r_total      <= '0;
      r_chan       <= 1'b0;
      r_in_idx     <= '0;
      r_out_idx    <= '0;
      r_ready      <= 1'b1;
      r_hard_valid <= 1'b0;
      r_hard       <= 1'b0;
      r_valid      <= 1'b0;
      r_sign       <= 1'b0;
      r_last       <= 1'b0;
`ifdef SIGN_FLIP_STAT_EN
      r_flip_cnt   <= '0;
`endif
    end else begin
      r_hard_valid <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_accept_in) begin
            r_buf[r_in_idx] <= i_sign;
            if (r_in_idx == '0) begin
              r_chan <= i_chan_sign;
              r_ones <= CNT_W'(i_sign);
            end else begin
              r_ones <= r_ones + CNT_W'(i_sign);
            end
            if (r_in_idx == LAST_IDX) begin
              r_in_idx <= '0;
              r_ready  <= 1'b0;
              r_state  <= S_DECIDE;
            end else begin
              r_in_idx <= r_in_idx + IDX_W'(1);
            end
          end
        end
        S_DECIDE: begin
          r_total      <= w_total;
          r_hard       <= w_hard;
          r_hard_valid <= 1'b1;
          r_valid      <= 1'b1;
          r_out_idx    <= '0;
          r_sign       <= w_sign0;
          r_last       <= 1'b0;
`ifdef SIGN_FLIP_STAT_EN
          if ((w_hard != r_chan) && (r_flip_cnt != 16'hFFFF))
            r_flip_cnt <= r_flip_cnt + 16'd1;
`endif
          r_state      <= S_EMIT;
        end
        S_EMIT: begin
          if (w_accept_out) begin
            if (r_last) begin
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_sign    <= 1'b0;
              r_out_idx <= '0;
              r_in_idx  <= '0;
              r_ones    <= '0;
              r_ready   <= 1'b1;
              r_state   <= S_COLLECT;
            end else begin
              r_out_idx <= w_next_idx;
              r_sign    <= w_sign_nx;
              r_last    <= (w_next_idx == LAST_IDX);
            end
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_state <= S_COLLECT;
        end
      endcase
    end
  end

  assign o_ready      = r_ready;
  assign o_hard_valid = r_hard_valid;
  assign o_hard       = r_hard;
  assign o_valid      = r_valid;
  assign o_sign       = r_sign;
  assign o_idx        = r_out_idx;
  assign o_last       = r_last;
`ifdef SIGN_FLIP_STAT_EN
  assign o_flip_cnt   = r_flip_cnt;
`endif

endmodule

// File: tb/tb_sign_extrinsic_dist.sv
// Scoreboard bench for sign_extrinsic_dist: frames are driven by the main
// process, expectations are queued from a majority-vote model, and a monitor
// compares every hard decision and every transferred extrinsic beat.
module tb_sign_extrinsic_dist;

  localparam int DEG   = 4;
  localparam int IDX_W = $clog2(DEG);

  typedef struct {
    logic hard;
    logic chan;
    int   cyc;
  } hard_t;

  typedef struct {
    logic             sign;
    logic [IDX_W-1:0] idx;
    logic             last;
  } out_t;

  logic             clk;
  logic             i_reset;
  logic             i_valid;
  logic             o_ready;
  logic             i_sign;
  logic             i_chan_sign;
  logic             o_hard_valid;
  logic             o_hard;
  logic             o_valid;
  logic             i_ready;
  logic             o_sign;
  logic [IDX_W-1:0] o_idx;
  logic             o_last;
`ifdef SIGN_FLIP_STAT_EN
  logic [15:0]      o_flip_cnt;
  int               exp_flip;
`endif

  int    n_vec;
  int    n_err;
  int    cyc;
  int    ready_mode;
  int    stall_left;
  bit    stalled;
  bit    held;
  logic  held_sign;
  logic  held_last;
  logic [IDX_W-1:0] held_idx;
  hard_t hard_q[$];
  out_t  out_q[$];

  sign_extrinsic_dist #(.DEG(DEG)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_sign       (i_sign),
    .i_chan_sign  (i_chan_sign),
    .o_hard_valid (o_hard_valid),
    .o_hard       (o_hard),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sign       (o_sign),
    .o_idx        (o_idx),
    .o_last       (o_last)
`ifdef SIGN_FLIP_STAT_EN
    ,
    .o_flip_cnt   (o_flip_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: strict majority of the voters, ties resolved to the channel sign.
  function automatic logic vote(input int yes, input int voters, input logic tie);
    if (2 * yes > voters)      return 1'b1;
    else if (2 * yes < voters) return 1'b0;
    else                       return tie;
  endfunction

  task automatic push_expect(input logic chan, input logic [DEG-1:0] sgn, input int acc_cyc);
    hard_t h;
    out_t  o;
    int    neg;
    neg    = $countones(sgn) + int'(chan);
    h.hard = vote(neg, DEG + 1, chan);
    h.chan = chan;
    h.cyc  = acc_cyc;
    hard_q.push_back(h);
    for (int k = 0; k < DEG; k++) begin
      o.sign = vote(neg - int'(sgn[k]), DEG, chan);
      o.idx  = IDX_W'(k);
      o.last = (k == DEG - 1);
      out_q.push_back(o);
    end
  endtask

  task automatic send_frame(input logic chan, input logic [DEG-1:0] sgn, input int gap);
    bit done;
    for (int k = 0; k < DEG; k++) begin
      i_valid     = 1'b1;
      i_sign      = sgn[k];
      i_chan_sign = chan;
      done        = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
        @(negedge clk);
        if (o_ready) begin
          done = 1'b1;
          if (k == DEG - 1) push_expect(chan, sgn, cyc);
        end
      end
      if (!done) fail_now("input_accept_timeout");
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((out_q.size() != 0 || hard_q.size() != 0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 1000) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready: always on, random, or a single 3-cycle stall at edge 1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) i_ready = 1'b1;
      else if (ready_mode == 1) i_ready = ($urandom_range(0, 3) != 0);
      else begin
        if (stall_left > 0) begin
          i_ready = 1'b0;
          stall_left--;
        end else if (!stalled && o_valid && o_idx == IDX_W'(1)) begin
          i_ready    = 1'b0;
          stall_left = 2;
          stalled    = 1'b1;
        end else begin
          i_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: compares hard decisions and every transferred output beat.
  always @(negedge clk) begin
    hard_t h;
    out_t  o;
    if (i_reset) begin
      held = 1'b0;
    end else begin
      if (o_hard_valid) begin
        if (hard_q.size() == 0) fail_now("hard_valid_spurious");
        else begin
          h = hard_q.pop_front();
          chk("hard", 32'(o_hard), 32'(h.hard));
          chk("hard_latency", 32'(cyc - h.cyc), 32'd2);
`ifdef SIGN_FLIP_STAT_EN
          if (h.hard != h.chan && exp_flip < 65535) exp_flip++;
          chk("flip_cnt", 32'(o_flip_cnt), 32'(exp_flip));
`endif
        end
      end
      if (held) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_sign", 32'(o_sign), 32'(held_sign));
        chk("hold_idx", 32'(o_idx), 32'(held_idx));
        chk("hold_last", 32'(o_last), 32'(held_last));
      end
      if (o_valid) chk("ready_low_in_emit", 32'(o_ready), 32'd0);
      if (o_valid && i_ready) begin
        if (out_q.size() == 0) fail_now("out_beat_spurious");
        else begin
          o = out_q.pop_front();
          chk("ext_sign", 32'(o_sign), 32'(o.sign));
          chk("ext_idx", 32'(o_idx), 32'(o.idx));
          chk("ext_last", 32'(o_last), 32'(o.last));
        end
      end
      held      = o_valid && !i_ready;
      held_sign = o_sign;
      held_idx  = o_idx;
      held_last = o_last;
    end
  end

  initial begin
    bit found;
    n_vec = 0; n_err = 0; cyc = 0;
    ready_mode = 0; stall_left = 0; stalled = 1'b0; held = 1'b0;
    i_reset = 1'b1; i_valid = 1'b0; i_sign = 1'b0; i_chan_sign = 1'b0; i_ready = 1'b1;
`ifdef SIGN_FLIP_STAT_EN
    exp_flip = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_hard_valid", 32'(o_hard_valid), 32'd0);
    chk("rst_hard", 32'(o_hard), 32'd0);
    chk("rst_sign", 32'(o_sign), 32'd0);
    chk("rst_idx", 32'(o_idx), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
`ifdef SIGN_FLIP_STAT_EN
    chk("rst_flip", 32'(o_flip_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Directed frames (bit k = sign of edge k).
    send_frame(1'b0, 4'b0111, 0);
    send_frame(1'b0, 4'b0000, 0);
    send_frame(1'b1, 4'b0100, 0);
    wait_drain();

    // Three-cycle backpressure at edge 1.
    ready_mode = 2;
    send_frame(1'b0, 4'b1011, 0);
    wait_drain();
    ready_mode = 0;

    // Gapped input, then the same frame back-to-back without gaps.
    send_frame(1'b1, 4'b1101, 1);
    send_frame(1'b1, 4'b1101, 0);
    send_frame(1'b0, 4'b0111, 1);
    wait_drain();

    // Randomized frames with random gaps and random downstream ready.
    ready_mode = 1;
    for (int f = 0; f < 40; f++)
      send_frame(1'($urandom()), DEG'($urandom()), int'($urandom_range(0, 2)));
    wait_drain();
    ready_mode = 0;

    // Reset in the middle of EMIT at edge 2.
    send_frame(1'b0, 4'b0111, 0);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (o_valid && o_idx == IDX_W'(2)) found = 1'b1;
    end
    if (!found) fail_now("emit_idx2_timeout");
    #2;
    i_reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    out_q.delete();
    hard_q.delete();
`ifdef SIGN_FLIP_STAT_EN
    exp_flip = 0;
    chk("mid_rst_flip", 32'(o_flip_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    send_frame(1'b0, 4'b0111, 0);
    send_frame(1'b1, 4'b0000, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

endmodule
